// File: rtl/csa_pkg.sv
// Shared types and constants for the carry-save multi-operand accumulator.
package csa_pkg;

  localparam int unsigned DefWidth  = 8;
  localparam int unsigned DefNOps   = 4;
  localparam int unsigned DefAccW   = 16;
  localparam int unsigned DefCntW   = 8;
  localparam bit          DefSigned = 1'b0;

  typedef enum logic [1:0] {
    StIdle,
    StAccum,
    StResolve,
    StOutput
  } state_e;

  // Operands are widened to the accumulator width before reduction.
  function automatic int unsigned ext_width(int unsigned width, int unsigned acc_w);
    return (acc_w > width) ? acc_w : width;
  endfunction

endpackage

// File: rtl/csa_3to2.sv
// One row of full adders: three W-bit vectors in, sum and unshifted carry out.
module csa_3to2 #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/csa_accumulator.sv
// Streaming N-operand accumulator: carry-save running total per beat,
// a single carry-propagate add once the frame's last beat has been taken.
module csa_accumulator
  import csa_pkg::*;
#(
  parameter int unsigned WIDTH  = DefWidth,
  parameter int unsigned N_OPS  = DefNOps,
  parameter int unsigned ACC_W  = DefAccW,
  parameter int unsigned CNT_W  = DefCntW,
  parameter bit          SIGNED = DefSigned
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N_OPS*WIDTH-1:0] in_ops,
  input  logic                   in_last,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_W-1:0]       out_sum,
  output logic [CNT_W-1:0]       out_beats
);

  localparam int unsigned EW = ext_width(WIDTH, ACC_W);

  state_e state_q, state_d;

  logic [ACC_W-1:0] acc_s_q, acc_s_d;
  logic [ACC_W-1:0] acc_c_q, acc_c_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [ACC_W-1:0] out_sum_q, out_sum_d;
  logic [CNT_W-1:0] out_beats_q, out_beats_d;

  logic accept;
  logic [EW-1:0]    ext_ops [N_OPS];
  logic [ACC_W-1:0] row_s   [N_OPS+1];
  logic [ACC_W-1:0] row_c   [N_OPS+1];
  logic [ACC_W-1:0] raw_c   [N_OPS];

  always_comb begin
    for (int k = 0; k < N_OPS; k++) begin
      if (SIGNED) begin
        ext_ops[k] = EW'($signed(in_ops[k*WIDTH +: WIDTH]));
      end else begin
        ext_ops[k] = EW'(in_ops[k*WIDTH +: WIDTH]);
      end
    end
  end

  // row_c holds carries already shifted into their weight; the top carry falls off (mod 2^ACC_W).
  assign row_s[0] = acc_s_q;
  assign row_c[0] = acc_c_q;

  for (genvar g = 0; g < N_OPS; g++) begin : g_row
    csa_3to2 #(
      .W (ACC_W)
    ) u_row (
      .a     (row_s[g]),
      .b     (row_c[g]),
      .c     (ext_ops[g]),
      .sum   (row_s[g+1]),
      .carry (raw_c[g])
    );
    assign row_c[g+1] = raw_c[g] << 1;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StAccum: begin
        if (accept) state_d = in_last ? StResolve : StAccum;
      end
      StResolve: state_d = StOutput;
      StOutput: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs; in_ready is gated by reset so nothing is offered while it is held.
  always_comb begin
    in_ready  = rst_n && ((state_q == StIdle) || (state_q == StAccum));
    out_valid = (state_q == StOutput);
  end

  assign accept = in_valid && in_ready;

  always_comb begin
    acc_s_d     = acc_s_q;
    acc_c_d     = acc_c_q;
    count_d     = count_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    if (accept) begin
      acc_s_d = row_s[N_OPS];
      acc_c_d = row_c[N_OPS];
      if (count_q != {CNT_W{1'b1}}) count_d = count_q + CNT_W'(1);
    end else if (out_valid && out_ready) begin
      acc_s_d = '0;
      acc_c_d = '0;
      count_d = '0;
    end
    if (state_q == StResolve) begin
      out_sum_d   = acc_s_q + acc_c_q;
      out_beats_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_s_q     <= '0;
      acc_c_q     <= '0;
      count_q     <= '0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
    end else begin
      acc_s_q     <= acc_s_d;
      acc_c_q     <= acc_c_d;
      count_q     <= count_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;

endmodule

// File: doc/csa_accumulator.md
Name: csa_accumulator

Overview:
- Streaming multi-operand accumulator that generalises the 4-operand carry-save adder to N_OPS operands of WIDTH bits per beat.
- Keeps a redundant (sum, carry) running total across a multi-beat frame using carry-save reduction, so no carry propagation happens per beat.
- Does one carry-propagate add when the frame ends.
- Sits between an operand producer and a result consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8: operand width in bits.
- N_OPS, 4: operands per beat; must be ≥2.
- ACC_W, 16: accumulator/result width; must be ≥WIDTH; results are modulo 2^ACC_W.
- CNT_W, 8: beat-counter width.
- SIGNED, 0: 0 = zero-extend operands to ACC_W; 1 = sign-extend.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat.
- in_ops  in  N_OPS*WIDTH  packed operands; op k = bits [k*WIDTH +: WIDTH].
- in_last  in  1  final beat of frame.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_sum  out  ACC_W  resolved frame total.
- out_beats  out  CNT_W  beats accepted in frame, saturating.

Behaviour:
- Reset: one clock and one reset only. Reset is synchronous and active-low; clock port is clk, reset port is rst_n. While rst_n=0 at a rising edge:
  - state←IDLE;
  - acc_s, acc_c, out_sum, out_beats ← 0;
  - out_valid←0.
  - in_ready is 0 during reset cycles, 1 in the first cycle after release.
- FSM states: IDLE, ACCUM, RESOLVE, OUTPUT.
  - in_ready=1 in IDLE/ACCUM, 0 in RESOLVE/OUTPUT.
  - out_valid=1 only in OUTPUT.
- Accept = in_valid & in_ready at a rising edge. On accept:
  - (acc_s, acc_c) ← 3:2 reduction of {acc_s, acc_c, ext(op0..opN-1)}.
  - Reduction uses N_OPS chained 3:2 compressor rows, all combinational within one cycle.
  - Each row's carry vector is shifted left 1 with the MSB dropped.
  - beat count increments, saturating at 2^CNT_W-1.
- Transitions:
  - IDLE→ACCUM on accept with in_last=0.
  - IDLE→RESOLVE on accept with in_last=1 (single-beat frame).
  - ACCUM→RESOLVE on accept with in_last=1; ACCUM holds when in_valid=0.
  - RESOLVE→OUTPUT unconditionally after one cycle. That edge registers out_sum←acc_s+acc_c (mod 2^ACC_W) and out_beats←count.
  - OUTPUT→IDLE on out_valid&out_ready. Same edge clears acc_s, acc_c and count; no beat is accepted on that edge.
- Latency: last beat accepted at edge T → out_valid high after edge T+1, i.e. the result is visible 2 cycles after acceptance of the last beat. Throughput is one frame per (beats+2) cycles minimum.
- Output stall: out_sum and out_beats are held stable while out_valid=1 and out_ready=0.
- in_ops and in_last are ignored whenever in_ready=0.
- Overflow wraps silently modulo 2^ACC_W; no flag.
- Reset mid-frame or with a pending result: frame is discarded and no output is produced.

Decomposition:
- Package csa_pkg holds:
  - state enum {IDLE, ACCUM, RESOLVE, OUTPUT};
  - localparam function for the extended operand width;
  - default parameter constants.
- Sub-module csa_3to2 (parametrised W): bitwise full-adder row, outputs sum and unshifted carry. It is generated N_OPS times in a chain; the parent applies the carry shift.

Test Plan:
1. Defaults; single beat in_ops = {0x78, 0x3C, 0x1E, 0x0F}, in_last=1, out_ready=1 → out_valid 2 cycles later, out_sum=0x00E1, out_beats=1.
2. Two beats of all 0xFF, in_last on the second → out_sum=0x07F8, out_beats=2. in_ready=0 during RESOLVE/OUTPUT.
3. Backpressure:
   - out_ready=0 for 5 cycles after out_valid → out_sum is stable and in_ready=0 throughout;
   - raising out_ready → IDLE next cycle;
   - a beat offered in the same cycle is not accepted until the following cycle.
4. Wrap/saturation with defaults:
   - 65 beats of all 0xFF → out_sum=0x02FC, out_beats=65.
   - With CNT_W=4, 20 beats → out_beats=15.
5. SIGNED=1, single beat ops {0x00, 0x01, 0xFF, 0xFF} → out_sum=0xFFFF (−1).
6. Assert rst_n=0 for one cycle midway through a 3-beat frame, then send a single beat {0x01, 0x01, 0x01, 0x01} with in_last=1 → out_sum=0x0004, out_beats=1, no stale result.
